// File: rtl/voting_pkg.sv
// Shared types and constants for the ballot session controller.
// Imported by the decision logic and the session sequencer.
package voting_pkg;

  localparam int N_VOTERS = 4;

  typedef enum logic [1:0] {
    IDLE,
    OPEN,
    DECIDE,
    HOLD
  } state_t;

  localparam logic [2:0] RES_NONE   = 3'b000;
  localparam logic [2:0] RES_ACCEPT = 3'b001;
  localparam logic [2:0] RES_TIE    = 3'b010;
  localparam logic [2:0] RES_REJECT = 3'b100;

endpackage

// File: rtl/ballot_decide.sv
// Combinational reduction of a ballot vector to a one-hot decision
// and a yes count; abstentions arrive here as zeros.
module ballot_decide
  import voting_pkg::*;
(
  input  logic [N_VOTERS-1:0] ballot,
  output logic [2:0]          result,
  output logic [2:0]          yes_count
);

  always_comb begin
    yes_count = 3'd0;
    for (int i = 0; i < N_VOTERS; i++) begin
      yes_count = yes_count + {2'b00, ballot[i]};
    end
  end

  always_comb begin
    result = RES_NONE;
    unique case (1'b1)
      (yes_count <  3'd2): result = RES_REJECT;
      (yes_count == 3'd2): result = RES_TIE;
      default:             result = RES_ACCEPT;
    endcase
  end

endmodule

// File: rtl/voting_session_ctrl.sv
// Four-voter ballot session sequencer: opens a timed window, latches
// first ballots, decides, and holds the result until acknowledged.
module voting_session_ctrl
  import voting_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int TW             = $clog2(TIMEOUT_CYCLES)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] vote_valid,
  input  logic [3:0] vote_val,
  input  logic       ack,
  output logic       busy,
  output logic [3:0] voted,
  output logic [2:0] result,
  output logic [2:0] yes_count,
  output logic       result_valid,
  output logic       timed_out
);

  state_t        state;
  logic [3:0]    ballot;
  logic [TW-1:0] timer;
  logic [3:0]    new_v;
  logic          all_in;
  logic          tmo;
  logic [2:0]    dec_res;
  logic [2:0]    dec_cnt;

  ballot_decide u_decide (
    .ballot    (ballot),
    .result    (dec_res),
    .yes_count (dec_cnt)
  );

  // Only first-time voters can change the ballot.
  assign new_v  = vote_valid & ~voted;
  assign all_in = ((voted | vote_valid) == 4'hF);
  assign tmo    = (timer == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ballot       <= 4'h0;
      voted        <= 4'h0;
      timer        <= '0;
      busy         <= 1'b0;
      result       <= RES_NONE;
      yes_count    <= 3'd0;
      result_valid <= 1'b0;
      timed_out    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state     <= OPEN;
            ballot    <= 4'h0;
            voted     <= 4'h0;
            timer     <= '0;
            busy      <= 1'b1;
            result    <= RES_NONE;
            yes_count <= 3'd0;
            timed_out <= 1'b0;
          end
        end
        OPEN: begin
          ballot <= (ballot & ~new_v) | (vote_val & new_v);
          voted  <= voted | vote_valid;
          timer  <= timer + TW'(1);
          if (all_in || tmo) begin
            state <= DECIDE;
          end
        end
        DECIDE: begin
          result       <= dec_res;
          yes_count    <= dec_cnt;
          timed_out    <= (voted != 4'hF);
          result_valid <= 1'b1;
          state        <= HOLD;
        end
        HOLD: begin
          if (ack) begin
            state        <= IDLE;
            result_valid <= 1'b0;
            busy         <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
